// File: rtl/mux2_1bit.sv
// mux2_1bit -- combinational single-bit 2:1 multiplexer.
//   in0 : selected when sel = 0
//   in1 : selected when sel = 1
//   sel : select
//   out : selected bit
module mux2_1bit (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_64bit.sv
// mux2_64bit -- WIDTH-lane 2:1 word selector with a registered output.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears f
//   w   : 2*WIDTH packed operand pairs; lane i = {w[2i+1], w[2i]}
//   s   : shared select, 0 -> even bit of each pair, 1 -> odd bit
//   f   : registered selected word, f[0] = lane 0
module mux2_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] w,
  input  logic               s,
  output logic [WIDTH-1:0]   f
);

  logic [WIDTH-1:0] sel_word;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux2_1bit u_mux (
      .in0 (w[2*i]),
      .in1 (w[2*i+1]),
      .sel (s),
      .out (sel_word[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
    end else begin
      f <= sel_word;
    end
  end

endmodule

// File: tb/tb_mux2_64bit.sv
module tb_mux2_64bit;

  logic         clk;
  logic         rst;
  logic [127:0] w;
  logic         s;
  logic [63:0]  f;

  int errors = 0;
  int checks = 0;

  mux2_64bit #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .s   (s),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shifting the packed pairs right by s puts the chosen bit of
  // every pair in the even position; then gather the even positions.
  function automatic logic [63:0] ref_word(input logic [127:0] wv, input logic sv);
    logic [127:0] sh;
    logic [63:0]  r;
    sh = wv >> sv;
    r  = '0;
    for (int k = 0; k < 64; k++) r[k] = sh[2*k];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] exp);
    checks++;
    assert (f === exp) else begin
      errors++;
      $error("FAIL %s: f=%h expected %h", tag, f, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [127:0] wv, input logic sv, input logic rv);
    @(negedge clk);
    w   = wv;
    s   = sv;
    rst = rv;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] rw;
  logic         rs;
  logic         rr;
  logic [63:0]  exp_f;

  initial begin
    w = '0; s = 1'b0; rst = 1'b1;

    // 1. Reset wins over all-ones data, then first free edge loads data
    step('1, 1'b1, 1'b1);            check("reset", 64'h0);
    step('1, 1'b1, 1'b0);            check("post_reset", 64'hFFFF_FFFF_FFFF_FFFF);

    // 2. All zero
    step('0, 1'b0, 1'b0);            check("zero_s0", 64'h0);
    step('0, 1'b1, 1'b0);            check("zero_s1", 64'h0);

    // 3. Lane 0 pairing
    step(128'h1, 1'b0, 1'b0);        check("l0_w1_s0", 64'h1);
    step(128'h1, 1'b1, 1'b0);        check("l0_w1_s1", 64'h0);
    step(128'h2, 1'b0, 1'b0);        check("l0_w2_s0", 64'h0);
    step(128'h2, 1'b1, 1'b0);        check("l0_w2_s1", 64'h1);
    step(128'h3, 1'b0, 1'b0);        check("l0_w3_s0", 64'h1);
    step(128'h3, 1'b1, 1'b0);        check("l0_w3_s1", 64'h1);

    // 4. Lane 1 pairing
    step(128'h4, 1'b0, 1'b0);        check("l1_w4_s0", 64'h2);
    step(128'h4, 1'b1, 1'b0);        check("l1_w4_s1", 64'h0);
    step(128'h6, 1'b0, 1'b0);        check("l1_w6_s0", 64'h2);
    step(128'h6, 1'b1, 1'b0);        check("l1_w6_s1", 64'h1);
    step(128'h5, 1'b0, 1'b0);        check("l1_w5_s0", 64'h3);
    step(128'h5, 1'b1, 1'b0);        check("l1_w5_s1", 64'h0);
    step(128'h7, 1'b0, 1'b0);        check("l1_w7_s0", 64'h3);
    step(128'h7, 1'b1, 1'b0);        check("l1_w7_s1", 64'h1);

    // 5. Odd/even separation across all lanes, including the top lane
    step({64{2'b10}}, 1'b0, 1'b0);   check("sep_s0", 64'h0);
    step({64{2'b10}}, 1'b1, 1'b0);   check("sep_s1", 64'hFFFF_FFFF_FFFF_FFFF);
    step(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0);
    check("top_lane_odd", 64'h8000_0000_0000_0000);
    step(128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    check("top_lane_even", 64'h8000_0000_0000_0000);

    // 6. Latency: s toggles every cycle, f follows one edge later
    rw = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      step(rw, k[0], 1'b0);
      check("toggle", ref_word(rw, k[0]));
    end
    // Reset asserted while s changes: reset wins, then selection resumes
    step(rw, 1'b0, 1'b1);            check("rst_prio", 64'h0);
    step(rw, 1'b1, 1'b0);            check("rst_resume", ref_word(rw, 1'b1));

    // Randomized traffic with occasional mid-stream resets
    for (int k = 0; k < 300; k++) begin
      rw = {$urandom, $urandom, $urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 7) == 0);
      step(rw, rs, rr);
      exp_f = rr ? 64'h0 : ref_word(rw, rs);
      check("random", exp_f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
